// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Board-level reset and start-up sequencer for the SoC top. It debounces the
//   user push-button, then releases the memory-controller global reset and
//   after that its soft reset. It waits for DDR2 calibration, then releases
//   the CPU and peripheral reset.
//
// Ports
//   i_clock          system clock
//   i_reset_n        asynchronous active-low reset
//   i_key_n          raw push-button, low = pressed, asynchronous to i_clock
//   i_cal_success    calibration passed (level)
//   i_cal_fail       calibration failed (level)
//   o_global_reset_n memory-controller global reset, active low
//   o_soft_reset_n   memory-controller soft reset, active low
//   o_cpu_reset      CPU/peripheral reset, active high
//   o_state          current state encoding, drives the status LEDs
//   o_cal_fault      sticky: the sequence ended in FAULT
//   o_cal_timeout    sticky: FAULT was caused by a calibration timeout
module reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int GLOBAL_CYCLES   = 64,
  parameter int SOFT_CYCLES     = 64,
  parameter int CAL_TIMEOUT     = 50000000,
  parameter int START_CYCLES    = 16
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_key_n,
  input  logic       i_cal_success,
  input  logic       i_cal_fail,
  output logic       o_global_reset_n,
  output logic       o_soft_reset_n,
  output logic       o_cpu_reset,
  output logic [2:0] o_state,
  output logic       o_cal_fault,
  output logic       o_cal_timeout
);

  localparam int MAX_GS  = (GLOBAL_CYCLES > SOFT_CYCLES) ? GLOBAL_CYCLES : SOFT_CYCLES;
  localparam int MAX_CS  = (CAL_TIMEOUT > START_CYCLES) ? CAL_TIMEOUT : START_CYCLES;
  localparam int MAX_PH  = (MAX_GS > MAX_CS) ? MAX_GS : MAX_CS;
  localparam int PW      = $clog2(MAX_PH) + 1;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [PW-1:0] GLOBAL_LAST = PW'(GLOBAL_CYCLES - 1);
  localparam logic [PW-1:0] SOFT_LAST   = PW'(SOFT_CYCLES - 1);
  localparam logic [PW-1:0] CAL_LAST    = PW'(CAL_TIMEOUT - 1);
  localparam logic [PW-1:0] START_LAST  = PW'(START_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_GLOBAL = 3'd0,
    S_SOFT   = 3'd1,
    S_CAL    = 3'd2,
    S_HOLD   = 3'd3,
    S_RUN    = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // ---------------- key synchroniser and debounce ----------------
  logic          key_s1_q, key_s2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] db_q, db_d;
  logic          press;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      stable_q <= 1'b1;
      db_q     <= '0;
    end else begin
      key_s1_q <= i_key_n;
      key_s2_q <= key_s1_q;
      stable_q <= stable_d;
      db_q     <= db_d;
    end
  end

  // The press pulse is raised in the same cycle the stable level is about to
  // flip 1->0, so the sequencer restarts on the very edge the key is accepted.
  always_comb begin
    stable_d = stable_q;
    db_d     = db_q;
    press    = 1'b0;
    if (key_s2_q == stable_q) begin
      db_d = '0;
    end else if (db_q == DB_LAST) begin
      stable_d = key_s2_q;
      db_d     = '0;
      press    = ~key_s2_q;
    end else begin
      db_d = db_q + DW'(1);
    end
  end

  // ---------------- sequencer FSM ----------------
  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          flt_q, flt_d, to_q, to_d;
  logic          glob_q, glob_d, soft_q, soft_d, cpu_q, cpu_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_GLOBAL;
      ph_q    <= '0;
      flt_q   <= 1'b0;
      to_q    <= 1'b0;
      glob_q  <= 1'b0;
      soft_q  <= 1'b0;
      cpu_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      flt_q   <= flt_d;
      to_q    <= to_d;
      glob_q  <= glob_d;
      soft_q  <= soft_d;
      cpu_q   <= cpu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + PW'(1);
    flt_d   = flt_q;
    to_d    = to_q;
    case (state_q)
      S_GLOBAL: if (ph_q == GLOBAL_LAST) begin state_d = S_SOFT; ph_d = '0; end
      S_SOFT:   if (ph_q == SOFT_LAST)   begin state_d = S_CAL;  ph_d = '0; end
      S_CAL: begin
        if (i_cal_fail) begin
          state_d = S_FAULT; ph_d = '0; flt_d = 1'b1;
        end else if (i_cal_success) begin
          state_d = S_HOLD;  ph_d = '0;
        end else if (ph_q == CAL_LAST) begin
          state_d = S_FAULT; ph_d = '0; flt_d = 1'b1; to_d = 1'b1;
        end
      end
      S_HOLD:   if (ph_q == START_LAST)  begin state_d = S_RUN;  ph_d = '0; end
      // Terminal states park the counter so it never wraps.
      S_RUN:    ph_d = ph_q;
      S_FAULT:  ph_d = ph_q;
      default: begin state_d = S_GLOBAL; ph_d = '0; end
    endcase
    // A debounced press restarts the whole sequence and beats everything else.
    if (press) begin
      state_d = S_GLOBAL;
      ph_d    = '0;
      flt_d   = 1'b0;
      to_d    = 1'b0;
    end
  end

  // Outputs are decoded from the next state and registered, so they change on
  // the same edge as the state itself.
  always_comb begin
    glob_d = (state_d != S_GLOBAL);
    soft_d = (state_d != S_GLOBAL) && (state_d != S_SOFT);
    cpu_d  = (state_d != S_RUN);
  end

  assign o_global_reset_n = glob_q;
  assign o_soft_reset_n   = soft_q;
  assign o_cpu_reset      = cpu_q;
  assign o_state          = state_q;
  assign o_cal_fault      = flt_q;
  assign o_cal_timeout    = to_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, key_n, cal_ok, cal_fail;
  logic       g_n, s_n, cpu;
  logic [2:0] st;
  logic       flt, tmo;

  reset_sequencer #(
    .DEBOUNCE_CYCLES(4), .GLOBAL_CYCLES(3), .SOFT_CYCLES(2),
    .CAL_TIMEOUT(10), .START_CYCLES(2)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_key_n(key_n),
    .i_cal_success(cal_ok), .i_cal_fail(cal_fail),
    .o_global_reset_n(g_n), .o_soft_reset_n(s_n), .o_cpu_reset(cpu),
    .o_state(st), .o_cal_fault(flt), .o_cal_timeout(tmo)
  );

  always #5 clk = ~clk;

  // Free-running edge counter; never reset, so expectations use absolute edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic       g, s, cpu, f, t;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expected outputs after edge 'c' (sampled on the following falling edge).
  task automatic expect_at(input int c, input logic [2:0] e_st, input logic e_g,
                           input logic e_s, input logic e_cpu, input logic e_f,
                           input logic e_t, input string nm);
    exp_t e;
    e.at = c; e.st = e_st; e.g = e_g; e.s = e_s; e.cpu = e_cpu;
    e.f = e_f; e.t = e_t; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: pops every expectation due at this edge and compares.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (e.at < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for edge %0d checked late at edge %0d", e.nm, e.at, cyc);
      end else if ({st, g_n, s_n, cpu, flt, tmo} !== {e.st, e.g, e.s, e.cpu, e.f, e.t}) begin
        n_bad++;
        $display("FAIL %s @%0d: got st=%0d g=%b s=%b cpu=%b flt=%b to=%b, want st=%0d g=%b s=%b cpu=%b flt=%b to=%b",
                 e.nm, cyc, st, g_n, s_n, cpu, flt, tmo, e.st, e.g, e.s, e.cpu, e.f, e.t);
      end
    end
  end

  // Advance to just after edge c.
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Standard sequence timing after a restart whose GLOBAL entry edge is b
  // (b = reset release edge counts as edge 0 of the sequence).
  task automatic expect_seq(input int b, input string tag);
    expect_at(b + 2, 3'd0, 0, 0, 1, 0, 0, {tag, "_global_low"});
    expect_at(b + 3, 3'd1, 1, 0, 1, 0, 0, {tag, "_soft"});
    expect_at(b + 4, 3'd1, 1, 0, 1, 0, 0, {tag, "_soft_low"});
    expect_at(b + 5, 3'd2, 1, 1, 1, 0, 0, {tag, "_cal"});
    expect_at(b + 6, 3'd3, 1, 1, 1, 0, 0, {tag, "_hold"});
    expect_at(b + 7, 3'd3, 1, 1, 1, 0, 0, {tag, "_hold2"});
    expect_at(b + 8, 3'd4, 1, 1, 0, 0, 0, {tag, "_run"});
  endtask

  int c0;

  initial begin
    rst_n = 1'b0; key_n = 1'b1; cal_ok = 1'b0; cal_fail = 1'b0;
    go(2);

    // 1. power-on path with calibration already passed
    c0 = cyc;
    expect_at(c0, 3'd0, 0, 0, 1, 0, 0, "reset_state");
    rst_n = 1'b1; cal_ok = 1'b1;
    expect_seq(c0, "pwr");
    go(c0 + 9);

    // 2. bounce rejection: 3-cycle low pulse is ignored
    c0 = cyc;
    key_n = 1'b0;
    go(c0 + 3);
    key_n = 1'b1;
    expect_at(c0 + 6, 3'd4, 1, 1, 0, 0, 0, "bounce_ignored");
    expect_at(c0 + 9, 3'd4, 1, 1, 0, 0, 0, "bounce_still_run");
    go(c0 + 12);
    // 8-cycle low is accepted 6 edges after the falling input
    c0 = cyc;
    key_n = 1'b0;
    expect_at(c0 + 5, 3'd4, 1, 1, 0, 0, 0, "press_not_yet");
    expect_at(c0 + 6, 3'd0, 0, 0, 1, 0, 0, "press_global");
    expect_seq(c0 + 6, "rerun");
    go(c0 + 8);
    key_n = 1'b1;
    go(c0 + 20);

    // 3. calibration timeout
    cal_ok = 1'b0;
    c0 = cyc;
    key_n = 1'b0;
    expect_at(c0 + 6, 3'd0, 0, 0, 1, 0, 0, "to_press");
    expect_at(c0 + 11, 3'd2, 1, 1, 1, 0, 0, "to_cal");
    expect_at(c0 + 20, 3'd2, 1, 1, 1, 0, 0, "to_cal_last");
    expect_at(c0 + 21, 3'd5, 1, 1, 1, 1, 1, "to_fault");
    expect_at(c0 + 40, 3'd5, 1, 1, 1, 1, 1, "to_fault_stays");
    go(c0 + 8);
    key_n = 1'b1;
    go(c0 + 41);

    // 5. recovery from FAULT by a press
    cal_ok = 1'b1;
    c0 = cyc;
    key_n = 1'b0;
    expect_at(c0 + 5, 3'd5, 1, 1, 1, 1, 1, "rec_before");
    expect_at(c0 + 6, 3'd0, 0, 0, 1, 0, 0, "rec_flags_clear");
    expect_seq(c0 + 6, "rec");
    go(c0 + 8);
    key_n = 1'b1;
    go(c0 + 20);

    // 4. success and fail together in CAL: fail wins, no timeout flag
    cal_ok = 1'b0;
    c0 = cyc;
    key_n = 1'b0;
    expect_at(c0 + 11, 3'd2, 1, 1, 1, 0, 0, "sim_cal");
    expect_at(c0 + 12, 3'd5, 1, 1, 1, 1, 0, "sim_fault");
    expect_at(c0 + 16, 3'd5, 1, 1, 1, 1, 0, "sim_fault_stays");
    go(c0 + 8);
    key_n = 1'b1;
    go(c0 + 11);
    cal_ok = 1'b1; cal_fail = 1'b1;
    go(c0 + 12);
    cal_ok = 1'b0; cal_fail = 1'b0;
    go(c0 + 20);

    // 6. asynchronous reset between edges while in RUN
    cal_ok = 1'b1;
    c0 = cyc;
    key_n = 1'b0;
    expect_at(c0 + 14, 3'd4, 1, 1, 0, 0, 0, "ar_run");
    go(c0 + 8);
    key_n = 1'b1;
    go(c0 + 15);
    #1;
    rst_n = 1'b0;
    expect_at(c0 + 15, 3'd0, 0, 0, 1, 0, 0, "ar_async");
    go(c0 + 17);
    c0 = cyc;
    rst_n = 1'b1;
    expect_seq(c0, "ar_restart");
    go(c0 + 10);

    @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: expectation for edge %0d never checked (now %0d)", e.nm, e.at, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
